i2c_target_ctrl: RTL and testbench
==================================

Name: i2c_target_ctrl

Overview:
Byte-level sequencer for the I2C target datapath. It detects START/STOP on synchronized SCL/SDA and matches the 7-bit address. It drives the control strobes of an external SIPO (receive, SIZE=8, UNIT=1) and PISO (transmit, SIZE=8, UNIT=1) and generates ACK/NACK on SDA through an open-drain enable. It sits between the pad logic and the downstream byte consumer/producer; no clock stretching.

Parameters:
ADDR, 7'h42, target address compared against the first 7 received bits
SYNC_STAGES, 2, synchronizer flops on scl_in/sda_in (minimum 2)

Ports:
clock  input  1  system clock, at least 8x SCL
reset  input  1  synchronous, active-high
scl_in  input  1  raw SCL from pad
sda_in  input  1  raw SDA from pad
sda_oe  output  1  1 = pull SDA low; 0 = release
sipo_clear  output  1  SIPO clear strobe
sipo_load  output  1  SIPO shift strobe
sipo_bit  output  1  synchronized SDA, wired to SIPO data_in
sipo_out  input  8  SIPO parallel output
sipo_full  input  1  SIPO holds 8 bits
piso_load  output  1  PISO parallel-load strobe
piso_spit  output  1  PISO shift strobe
piso_out  input  1  PISO MSB
rx_data  output  8  last received data byte
rx_valid  output  1  one-cycle pulse, rx_data updated
tx_req  output  1  one-cycle pulse; equal to piso_load; tx byte must be on PISO data_in this cycle
addressed  output  1  high from address ACK until STOP/START/NACK
rw  output  1  R/W bit of current transaction (1 = read)

Behaviour:
- Reset: state IDLE; all outputs 0; rx_data 8'h00; synchronizers set to 1 (bus idle). Reset mid-transfer releases SDA in the same cycle.
- Edge detection on synchronized signals, using previous-cycle samples:
  - scl_rise / scl_fall
  - START = SDA 1->0 while SCL high
  - STOP = SDA 0->1 while SCL high
- START in any state, including repeated START: sipo_clear pulse, sda_oe=0, addressed=0, go to ADDR. Takes priority over everything else in that cycle.
- STOP in any state: go to IDLE, sda_oe=0, addressed=0.
- Internal 4-bit bit counter: cleared on byte-phase entry, incremented on scl_rise.
- States:
  - IDLE: wait for START.
  - ADDR: sipo_load pulses on each scl_rise. When sipo_full=1:
    - sipo_out[7:1]==ADDR: latch rw=sipo_out[0], go to ADDR_ACK.
    - otherwise go to WAIT_STOP, SDA untouched.
  - ADDR_ACK: on next scl_fall set sda_oe=1 and addressed=1. On the following scl_fall (end of 9th clock):
    - rw=0: sda_oe=0, sipo_clear, go to RX.
    - rw=1: piso_load/tx_req pulse, go to TX.
  - RX: sipo_load on each scl_rise. The cycle sipo_full first rises: rx_data<=sipo_out, rx_valid pulse, go to RX_ACK.
  - RX_ACK: sda_oe=1 from next scl_fall to the following scl_fall, then sipo_clear and return to RX. Every data byte is ACKed.
  - TX: sda_oe = ~piso_out whenever in TX. piso_spit on scl_fall after bits 1..7. On scl_fall after bit 8: sda_oe=0, go to TX_ACK.
  - TX_ACK: sample SDA on scl_rise.
    - 0 (ACK): at next scl_fall, piso_load/tx_req, back to TX.
    - 1 (NACK): addressed=0, go to WAIT_STOP.
  - WAIT_STOP: sda_oe=0; leave only on START/STOP.
- Strobes are single-cycle. SDA changes only on scl_fall-derived cycles, never while SCL high.
- Latency: bus edge to strobe is SYNC_STAGES+1 clocks.

Test Plan:
- Write 0x84 (addr 0x42, W), data 0xA5, 0x3C, STOP -> ACK on 9th clocks; rx_valid twice with rx_data 8'hA5 then 8'h3C; rw=0; addressed falls at STOP.
- Read 0x85 with tx bytes 0x5A, 0xF0; master ACKs first, NACKs second -> SDA carries 0,1,0,1,1,0,1,0 then 1,1,1,1,0,0,0,0; two tx_req pulses; WAIT_STOP after NACK.
- Address 0x90 (addr 0x48) -> sda_oe stays 0 for entire frame; no rx_valid/tx_req; IDLE after STOP.
- Write 0x84, data 0x11, repeated START, 0x85 read -> state ADDR on repeated START, sipo_clear pulse, rw=1, first tx_req at end of address ACK.
- STOP after 4 data bits of a write -> IDLE, no rx_valid, sda_oe=0; next full write frame works.
- reset asserted while sda_oe=1 during ACK -> sda_oe=0 next clock; all outputs zero.

Source files
------------

// File: rtl/i2c_target_ctrl.sv
// Byte-level I2C target sequencer: START/STOP detection, address match,
// SIPO/PISO strobe generation and open-drain ACK/data drive on SDA.
module i2c_target_ctrl #(
    parameter logic [6:0]  ADDR        = 7'h42,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       sipo_clear,
    output logic       sipo_load,
    output logic       sipo_bit,
    input  logic [7:0] sipo_out,
    input  logic       sipo_full,
    output logic       piso_load,
    output logic       piso_spit,
    input  logic       piso_out,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    output logic       addressed,
    output logic       rw
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_RX,
        S_RX_ACK,
        S_TX,
        S_TX_ACK,
        S_WAIT_STOP
    } state_t;

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic       scl_s, sda_s, scl_prev, sda_prev;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [3:0] bit_cnt, bit_cnt_nx;
    logic       oe_q, oe_nx;
    logic       ack_q, ack_nx;
    logic       addressed_nx, rw_nx, rx_valid_nx;
    logic [7:0] rx_data_nx;
    logic       clear_c, load_c, pload_c, spit_c;

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    assign scl_rise  = scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s & scl_prev;
    assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
    assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;

    always_ff @(posedge clock) begin
        if (reset) begin
            scl_sync  <= '1;
            sda_sync  <= '1;
            scl_prev  <= 1'b1;
            sda_prev  <= 1'b1;
            state     <= S_IDLE;
            bit_cnt   <= '0;
            oe_q      <= 1'b0;
            ack_q     <= 1'b0;
            addressed <= 1'b0;
            rw        <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
        end else begin
            scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync  <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_prev  <= scl_s;
            sda_prev  <= sda_s;
            state     <= state_nx;
            bit_cnt   <= bit_cnt_nx;
            oe_q      <= oe_nx;
            ack_q     <= ack_nx;
            addressed <= addressed_nx;
            rw        <= rw_nx;
            rx_data   <= rx_data_nx;
            rx_valid  <= rx_valid_nx;
        end
    end

    // In the ACK states oe_q doubles as the phase flag: 0 = waiting for the
    // fall that starts the 9th clock, 1 = ACK driven, waiting for its end.
    always_comb begin
        state_nx     = state;
        bit_cnt_nx   = bit_cnt;
        oe_nx        = oe_q;
        ack_nx       = ack_q;
        addressed_nx = addressed;
        rw_nx        = rw;
        rx_data_nx   = rx_data;
        rx_valid_nx  = 1'b0;
        clear_c      = 1'b0;
        load_c       = 1'b0;
        pload_c      = 1'b0;
        spit_c       = 1'b0;

        if (scl_rise) bit_cnt_nx = bit_cnt + 4'd1;

        if (start_det) begin
            state_nx     = S_ADDR;
            clear_c      = 1'b1;
            oe_nx        = 1'b0;
            addressed_nx = 1'b0;
            bit_cnt_nx   = '0;
        end else if (stop_det) begin
            state_nx     = S_IDLE;
            oe_nx        = 1'b0;
            addressed_nx = 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    oe_nx = 1'b0;
                end
                S_ADDR: begin
                    load_c = scl_rise;
                    if (sipo_full) begin
                        if (sipo_out[7:1] == ADDR) begin
                            rw_nx    = sipo_out[0];
                            state_nx = S_ADDR_ACK;
                        end else begin
                            state_nx = S_WAIT_STOP;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_nx        = 1'b1;
                            addressed_nx = 1'b1;
                        end else begin
                            oe_nx      = 1'b0;
                            bit_cnt_nx = '0;
                            if (rw) begin
                                pload_c  = 1'b1;
                                state_nx = S_TX;
                            end else begin
                                clear_c  = 1'b1;
                                state_nx = S_RX;
                            end
                        end
                    end
                end
                S_RX: begin
                    load_c = scl_rise;
                    if (sipo_full) begin
                        rx_data_nx  = sipo_out;
                        rx_valid_nx = 1'b1;
                        state_nx    = S_RX_ACK;
                    end
                end
                S_RX_ACK: begin
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_nx = 1'b1;
                        end else begin
                            oe_nx      = 1'b0;
                            clear_c    = 1'b1;
                            bit_cnt_nx = '0;
                            state_nx   = S_RX;
                        end
                    end
                end
                S_TX: begin
                    if (scl_fall) begin
                        if (bit_cnt >= 4'd8) begin
                            ack_nx   = 1'b0;
                            state_nx = S_TX_ACK;
                        end else if (bit_cnt != 4'd0) begin
                            spit_c = 1'b1;
                        end
                    end
                end
                S_TX_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            addressed_nx = 1'b0;
                            state_nx     = S_WAIT_STOP;
                        end else begin
                            ack_nx = 1'b1;
                        end
                    end else if (scl_fall && ack_q) begin
                        pload_c    = 1'b1;
                        bit_cnt_nx = '0;
                        state_nx   = S_TX;
                    end
                end
                S_WAIT_STOP: begin
                    oe_nx = 1'b0;
                end
            endcase
        end
    end

    // Reset gates the combinational outputs so SDA is released immediately.
    assign sda_oe     = ~reset & ((state == S_TX) ? ~piso_out : oe_q);
    assign sipo_clear = ~reset & clear_c;
    assign sipo_load  = ~reset & load_c;
    assign sipo_bit   = ~reset & sda_s;
    assign piso_load  = ~reset & pload_c;
    assign piso_spit  = ~reset & spit_c;
    assign tx_req     = piso_load;

endmodule

// File: tb/tb_i2c_target_ctrl.sv
// Bench for i2c_target_ctrl: bus-level master, SIPO/PISO models and a
// transaction-level expectation of ACKs, received bytes and read data.
module tb_i2c_target_ctrl;

    localparam logic [6:0]  ADDR = 7'h42;
    localparam int unsigned SYNC = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic sda_bus;

    logic       sda_oe, sipo_clear, sipo_load, sipo_bit, sipo_full;
    logic       piso_load, piso_spit, piso_out, rx_valid, tx_req, addressed, rw;
    logic [7:0] sipo_out, rx_data;

    int checks = 0;
    int errors = 0;
    int txreq_cnt = 0;
    int clear_cnt = 0;
    int oe_cycles = 0;
    int half = 6;
    bit chk_en = 1'b0;
    logic exp_oe = 1'b0;

    logic [7:0] dbuf [8];
    logic [7:0] tx_q [$];
    logic [7:0] exp_rx [$];
    logic [7:0] rx_log [$];
    logic [7:0] rd_log [$];

    logic [7:0] sreg, preg;
    logic [3:0] scnt;

    always #5 clock = ~clock;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_target_ctrl #(.ADDR(ADDR), .SYNC_STAGES(SYNC)) dut (
        .clock      (clock),
        .reset      (reset),
        .scl_in     (scl_m),
        .sda_in     (sda_bus),
        .sda_oe     (sda_oe),
        .sipo_clear (sipo_clear),
        .sipo_load  (sipo_load),
        .sipo_bit   (sipo_bit),
        .sipo_out   (sipo_out),
        .sipo_full  (sipo_full),
        .piso_load  (piso_load),
        .piso_spit  (piso_spit),
        .piso_out   (piso_out),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_req     (tx_req),
        .addressed  (addressed),
        .rw         (rw)
    );

    // External SIPO/PISO as seen by the controller.
    always @(posedge clock) begin
        if (reset) begin
            sreg <= '0;
            scnt <= '0;
            preg <= '0;
        end else begin
            if (sipo_clear) begin
                sreg <= '0;
                scnt <= '0;
            end else if (sipo_load) begin
                sreg <= {sreg[6:0], sipo_bit};
                if (scnt < 4'd8) scnt <= scnt + 4'd1;
            end
            if (piso_load) begin
                if (tx_q.size() > 0) preg <= tx_q.pop_front();
                else preg <= '0;
            end else if (piso_spit) begin
                preg <= {preg[6:0], 1'b0};
            end
        end
    end
    assign sipo_out  = sreg;
    assign sipo_full = (scnt == 4'd8);
    assign piso_out  = preg[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (tx_req) txreq_cnt++;
            if (sipo_clear) clear_cnt++;
            if (sda_oe) oe_cycles++;
            if (chk_en && scl_m) check("sda_oe_while_scl_high", sda_oe, exp_oe);
            if (tx_req || piso_load) check("tx_req_eq_piso_load", tx_req, piso_load);
            if (rx_valid) begin
                rx_log.push_back(rx_data);
                if (exp_rx.size() == 0) check("rx_valid_unexpected", rx_valid, 0);
                else check("rx_data", rx_data, exp_rx.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic bus_bit(input logic b, input logic eoe, output logic rb);
        sda_m  = b;
        exp_oe = eoe;
        tick(half);
        scl_m = 1'b1;
        tick(half / 2);
        rb = sda_bus;
        tick(half - half / 2);
        scl_m = 1'b0;
        tick(1);
    endtask

    task automatic start_cond();
        int c0;
        exp_oe = 1'b0;
        sda_m  = 1'b1;
        tick(half);
        scl_m = 1'b1;
        tick(half);
        c0 = clear_cnt;
        sda_m = 1'b0;
        tick(half);
        check("start_sipo_clear", clear_cnt - c0, 1);
        scl_m = 1'b0;
        tick(1);
    endtask

    task automatic stop_cond();
        exp_oe = 1'b0;
        sda_m  = 1'b0;
        tick(half);
        scl_m = 1'b1;
        tick(half);
        sda_m = 1'b1;
        tick(half);
    endtask

    // Expected bus behaviour: ACK only on a matching address and on every
    // data byte of a matching write; reads put dbuf on SDA, else bus floats.
    task automatic frame(input logic [6:0] a, input logic r, input int n, input bit do_stop);
        logic match, rb;
        logic [7:0] byt, got;
        int t0;
        match = (a == ADDR);
        t0 = txreq_cnt;
        if (match && r) for (int i = 0; i < n; i++) tx_q.push_back(dbuf[i]);
        start_cond();
        byt = {a, r};
        for (int k = 7; k >= 0; k--) bus_bit(byt[k], 1'b0, rb);
        bus_bit(1'b1, match, rb);
        check("addr_ack_bus", rb, !match);
        check("addressed_after_addr", addressed, match);
        if (match) check("rw", rw, r);
        for (int i = 0; i < n; i++) begin
            if (!r) begin
                if (match) exp_rx.push_back(dbuf[i]);
                for (int k = 7; k >= 0; k--) bus_bit(dbuf[i][k], 1'b0, rb);
                bus_bit(1'b1, match, rb);
                check("data_ack_bus", rb, !match);
            end else begin
                got = '0;
                for (int k = 7; k >= 0; k--) begin
                    bus_bit(1'b1, match && !dbuf[i][k], rb);
                    got[k] = rb;
                end
                rd_log.push_back(got);
                check("read_byte", got, match ? dbuf[i] : 8'hFF);
                check("tx_req_so_far", txreq_cnt - t0, match ? i + 1 : 0);
                bus_bit(i == n - 1, 1'b0, rb);
            end
        end
        if (match && r) check("addressed_after_nack", addressed, 0);
        if (do_stop) begin
            stop_cond();
            tick(2);
            check("addressed_after_stop", addressed, 0);
            check("rx_pending", exp_rx.size(), 0);
            check("tx_req_count", txreq_cnt - t0, (match && r) ? n : 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rb;
        int t_oe, waited;
        logic [7:0] byt;

        tick(5);
        check("reset_outputs", {sda_oe, sipo_clear, sipo_load, piso_load, piso_spit,
                                rx_valid, tx_req, addressed, rw, rx_data}, 0);
        reset = 1'b0;
        tick(4);
        check("idle_oe", sda_oe, 0);
        chk_en = 1'b1;

        // Write 0x84: A5, 3C
        rx_log.delete();
        dbuf[0] = 8'hA5; dbuf[1] = 8'h3C;
        frame(7'h42, 1'b0, 2, 1'b1);
        check("wr_rx_count", rx_log.size(), 2);
        if (rx_log.size() >= 2) begin
            check("wr_rx0_literal", rx_log[0], 8'hA5);
            check("wr_rx1_literal", rx_log[1], 8'h3C);
        end

        // Read 0x85: 5A (ACK), F0 (NACK)
        rd_log.delete();
        dbuf[0] = 8'h5A; dbuf[1] = 8'hF0;
        frame(7'h42, 1'b1, 2, 1'b1);
        check("rd_count", rd_log.size(), 2);
        if (rd_log.size() >= 2) begin
            check("rd0_literal", rd_log[0], 8'h5A);
            check("rd1_literal", rd_log[1], 8'hF0);
        end

        // Foreign address 0x48
        t_oe = oe_cycles;
        dbuf[0] = 8'h77; dbuf[1] = 8'h00;
        frame(7'h48, 1'b0, 2, 1'b1);
        check("foreign_oe_cycles", oe_cycles - t_oe, 0);

        // Write 0x11, repeated START, read one byte
        dbuf[0] = 8'h11;
        frame(7'h42, 1'b0, 1, 1'b0);
        dbuf[0] = 8'hC3;
        frame(7'h42, 1'b1, 1, 1'b1);

        // STOP after 4 data bits, then a full write
        start_cond();
        byt = 8'h84;
        for (int k = 7; k >= 0; k--) bus_bit(byt[k], 1'b0, rb);
        bus_bit(1'b1, 1'b1, rb);
        for (int k = 0; k < 4; k++) bus_bit(k[0], 1'b0, rb);
        stop_cond();
        tick(2);
        check("partial_oe", sda_oe, 0);
        check("partial_addressed", addressed, 0);
        dbuf[0] = 8'h96;
        frame(7'h42, 1'b0, 1, 1'b1);

        // Reset while the address ACK is being driven
        chk_en = 1'b0;
        start_cond();
        for (int k = 7; k >= 0; k--) bus_bit(byt[k], 1'b0, rb);
        sda_m = 1'b1;
        waited = 0;
        while (!sda_oe && waited < 40) begin
            tick(1);
            waited++;
        end
        check("ack_before_reset", sda_oe, 1);
        reset = 1'b1;
        #1;
        check("reset_same_cycle_oe", sda_oe, 0);
        tick(1);
        check("reset_midframe_outputs", {sda_oe, sipo_clear, sipo_load, sipo_bit, piso_load,
                                         piso_spit, rx_valid, tx_req, addressed, rw, rx_data}, 0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        tick(3);
        reset = 1'b0;
        tx_q.delete();
        exp_rx.delete();
        tick(6);
        chk_en = 1'b1;
        dbuf[0] = 8'h5C;
        frame(7'h42, 1'b0, 1, 1'b1);

        // Randomized frames
        for (int f = 0; f < 12; f++) begin
            logic [6:0] a;
            half = $urandom_range(5, 8);
            a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : ADDR;
            for (int i = 0; i < 8; i++) dbuf[i] = 8'($urandom);
            frame(a, 1'($urandom_range(0, 1)), $urandom_range(1, 3), 1'b1);
        end

        tick(4);
        check("tx_q_drained", tx_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
